// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, opcode encoding, default result width.
package alu_pkg;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned RESULT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpXor  = 3'd4,
    OpShl  = 3'd5,
    OpShr  = 3'd6,
    OpPass = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_result_buffer.sv
// ALU result buffer: first-word-fall-through FIFO of {opcode, result} with a
// valid/ready consumer side and a sticky overflow flag for dropped results.
// Optional feature macro ALU_FLAGS_EN: store a per-entry zero flag and present
// it on out_zero; when undefined, out_zero is tied to 0.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = RESULT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           result,
  input  logic [OP_W-1:0]            op,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [OP_W-1:0]            out_op,
  input  logic                       out_ready,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OP_W-1:0]  op_q   [DEPTH];

  logic push, pop, drop;

  // Handshake decode; in_ready depends only on occupancy, never on out_ready.
  always_comb begin
    in_ready  = (count_q != CntW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    drop      = in_valid && !in_ready;
  end

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; not reset, contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= result;
      op_q[wr_ptr_q]   <= op;
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q [DEPTH];

  // Zero flag captured at push time alongside the entry.
  always_ff @(posedge clk) begin
    if (push) zero_q[wr_ptr_q] <= (result == '0);
  end

  // Head zero flag.
  always_comb begin
    out_zero = zero_q[rd_ptr_q];
  end
`else
  // No flag storage in this build.
  always_comb begin
    out_zero = 1'b0;
  end
`endif

  // Head entry and status outputs, all from flop state.
  always_comb begin
    out_data = data_q[rd_ptr_q];
    out_op   = op_q[rd_ptr_q];
    count    = count_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer with a queue-based reference model.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef ALU_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic [2:0]       op;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op;
  logic             out_ready;
  logic             out_zero;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             ovf_clr;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {op, result}, plus sticky overflow bit.
  logic [WIDTH+2:0] mq[$];
  bit               m_ovf;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .result    (result),
    .op        (op),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_ready (out_ready),
    .out_zero  (out_zero),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Advance one clock and update the model from the inputs applied this cycle.
  task automatic cycle();
    bit               push, pop, drop;
    logic [WIDTH+2:0] ent;
    push = in_valid && (mq.size() < DEPTH);
    drop = in_valid && !push;
    pop  = out_ready && (mq.size() > 0);
    ent  = {op, result};
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(ent);
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    result    = '0;
    op        = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_asserted: in_ready=%b out_valid=%b count=%0d ovf=%b, want 1 0 0 0",
               in_ready, out_valid, count, ovf);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: in_ready=%b out_valid=%b count=%0d ovf=%b, want 1 0 0 0",
                 i, in_ready, out_valid, count, ovf);
      end
    end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1;
    result   = 8'h0C;
    op       = 3'd3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: out_valid=%b want 0", out_valid);
    end
    cycle();
    in_valid = 1'b0;
    result   = 8'hFF;
    op       = 3'd7;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0C || out_op !== 3'd3 || count !== CW'(1)) begin
        errors++;
        $display("FAIL single_head[%0d]: valid=%b data=%h op=%0d count=%0d, want 1 0c 3 1",
                 i, out_valid, out_data, out_op, count);
      end
      if (i < 3) cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL single_drain: valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      result   = WIDTH'(i);
      op       = 3'(i);
      if (i == 5) begin
        checks++;
        if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
          errors++;
          $display("FAIL fill_full: in_ready=%b count=%0d, want 0 %0d", in_ready, count, DEPTH);
        end
      end
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (ovf !== 1'b1 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL fill_ovf: ovf=%b count=%0d, want 1 %0d", ovf, count, DEPTH);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || out_op !== 3'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h op=%0d, want 1 %h %0d",
                 i, out_valid, out_data, out_op, WIDTH'(i), i);
      end
      cycle();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: valid=%b ovf=%b, want 0 1", out_valid, ovf);
    end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b want 0", ovf);
    end
    // Fill, then drop and clear together: the drop must win.
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      result = WIDTH'(8'h40 + i);
      cycle();
    end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr  = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b want 1", ovf);
    end
    out_ready = 1'b1;
    ovf_clr   = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle();
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL refill_drain: valid=%b ovf=%b, want 0 0", out_valid, ovf);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] base;
    base      = 8'h80;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op        = 3'd1;
    for (int j = 0; j < 20; j++) begin
      result = base + WIDTH'(j);
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== base + WIDTH'(j) || count !== CW'(1)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%h count=%0d, want 1 %h 1",
                 j, out_valid, out_data, count, base + WIDTH'(j));
      end
    end
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL stream_end: valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_zero_flag();
    in_valid = 1'b1;
    result   = 8'h00;
    op       = 3'd2;
    cycle();
    result = 8'h07;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 8'h00 || out_zero !== FlagsEn) begin
      errors++;
      $display("FAIL zero_first: data=%h zero=%b, want 00 %b", out_data, out_zero, FlagsEn);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_data !== 8'h07 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_second: data=%h zero=%b, want 07 0", out_data, out_zero);
    end
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      result = WIDTH'(8'h20 + i);
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL mid_count: count=%0d want 3", count);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b count=%0d in_ready=%b, want 0 0 1",
               out_valid, count, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    in_valid = 1'b1;
    result   = 8'h09;
    op       = 3'd5;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h09 || out_op !== 3'd5 || count !== CW'(1)) begin
      errors++;
      $display("FAIL mid_after_push: valid=%b data=%h op=%0d count=%0d, want 1 09 5 1",
               out_valid, out_data, out_op, count);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH+2:0] head;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      result    = WIDTH'($urandom_range(0, 15) == 0 ? 0 : $urandom);
      op        = 3'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      cycle();
      checks++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH) ||
          count !== CW'(mq.size()) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_status[%0d]: valid=%b ready=%b count=%0d ovf=%b, want cnt=%0d ovf=%b",
                 n, out_valid, in_ready, count, ovf, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        head = mq[0];
        checks++;
        if (out_data !== head[WIDTH-1:0] || out_op !== head[WIDTH+2:WIDTH] ||
            out_zero !== (FlagsEn && head[WIDTH-1:0] == '0)) begin
          errors++;
          $display("FAIL rand_head[%0d]: data=%h op=%0d zero=%b, want %h %0d", n, out_data,
                   out_op, out_zero, head[WIDTH-1:0], head[WIDTH+2:WIDTH]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_streaming();
    test_zero_flag();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
